sphere_scan: RTL and testbench
==============================

SPHERE_SCAN -- requirements
Module: sphere_scan

Interface
REQ-001 SHALL have parameter ADDR_W, 4, sphere-table address width (max 2^ADDR_W spheres).
REQ-002 SHALL have parameter TIMEOUT, 15, maximum WAIT cycles before a sphere is treated as a miss.
REQ-003 SHALL have clk  in  1  sole clock, rising edge.
REQ-004 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ray_start  in  1  one-cycle request; ray inputs and num_spheres sampled on the same edge.
REQ-006 SHALL have num_spheres  in  ADDR_W+1  count of table entries to scan.
REQ-007 SHALL have rayorig_x/_y/_z, raydir_x/_y/_z  in  32 each  ray, signed 16.16 fixed point.
REQ-008 SHALL have sph_rd  out  1 and sph_addr  out  ADDR_W  table read strobe and index.
REQ-009 SHALL have sph_center_x/_y/_z, sph_radius_sqr  in  32 each  table data, valid one cycle after sph_rd.
REQ-010 SHALL have isect_start  out  1  start pulse to the intersection unit.
REQ-011 SHALL have isect_rayorig_x/_y/_z, isect_raydir_x/_y/_z, isect_center_x/_y/_z, isect_radius_sqr  out  32 each  registered operands, held stable from START until UPDATE.
REQ-012 SHALL have isect_finish  in  1, isect_result  in  1, isect_t0/isect_t1  in  32  intersection response (finish is level, not pulse).
REQ-013 SHALL have busy  out  1, done  out  1 (pulse), hit  out  1, hit_idx  out  ADDR_W, hit_t  out  32  scan status and nearest hit.

Function
REQ-014 SHALL implement states IDLE, FETCH, LOAD, START, WAIT, UPDATE, DONE.
REQ-015 SHALL in IDLE on ray_start latch ray, set idx=0, best_t=0x7FFFFFFF, hit=0; go FETCH, or DONE if num_spheres=0.
REQ-016 SHALL in FETCH assert sph_rd with sph_addr=idx for exactly one cycle, then LOAD.
REQ-017 SHALL in LOAD register table data into isect_center_*/isect_radius_sqr, then START.
REQ-018 SHALL in START assert isect_start for exactly one cycle, then WAIT with wait counter cleared.
REQ-019 SHALL ignore isect_finish in the first WAIT cycle (stale level from previous operation) and sample it from the second WAIT cycle on.
REQ-020 SHALL leave WAIT for UPDATE on sampled isect_finish=1, or after TIMEOUT WAIT cycles with the sphere forced to miss.
REQ-021 SHALL form candidate t = isect_t0 if signed t0 > 0, else isect_t1.
REQ-022 SHALL accept in UPDATE when isect_result=1, not timed out, candidate signed > 0 and candidate < best_t (strict: equal t keeps lower index); accept loads best_t, hit_idx=idx, hit=1.
REQ-023 SHALL in UPDATE increment idx and go FETCH if idx+1 < num_spheres, else DONE.
REQ-024 SHALL in DONE pulse done one cycle, drive hit_t=best_t, return to IDLE; hit/hit_idx/hit_t hold until next ray_start.
REQ-025 SHALL assert busy in every state except IDLE; ray_start while busy is ignored.
REQ-026 SHALL complete each sphere in min 6 cycles (FETCH, LOAD, START, 2 WAIT, UPDATE); empty scan yields done 2 cycles after ray_start.
REQ-027 SHALL use signed 32-bit comparisons for all t values; no arithmetic widening needed.

Reset
REQ-028 SHALL on rst go IDLE next edge, from any state including mid-WAIT.
REQ-029 SHALL reset busy, done, hit, sph_rd, isect_start to 0, hit_idx to 0, hit_t and best_t to 0x7FFFFFFF, operand registers to 0.
REQ-030 SHALL give rst priority over ray_start on the same edge.

Structure
REQ-031 SHALL place state enum, FP_ONE=32'h00010000 and T_INF=32'h7FFFFFFF in shared package ray_pkg.
REQ-032 SHALL factor REQ-021/022 candidate select and compare into one combinational sub-module nearest_hit_sel.
REQ-033 SHALL not instantiate the intersection unit; it connects at the next level up.

Verification (behavioural intersection stub, finish latency programmable)
REQ-034 SHALL cover num_spheres=0, ray_start -> done 2 cycles later, hit=0, hit_t=0x7FFFFFFF.
REQ-035 SHALL cover 2 spheres, idx0 result=1 t0=0x00040000 t1=0x00060000, idx1 result=0 -> hit=1, hit_idx=0, hit_t=0x00040000.
REQ-036 SHALL cover 3 spheres all hit with t0=0x00060000, 0x00030000, 0x00030000 -> hit_idx=1, hit_t=0x00030000.
REQ-037 SHALL cover origin inside: t0=0xFFFF0000, t1=0x00020000 -> hit_t=0x00020000; stub holding finish=1 from previous op -> not sampled in first WAIT cycle.
REQ-038 SHALL cover stub never finishing on idx0, idx1 hit t0=0x00010000 -> idx0 skipped after TIMEOUT, hit_idx=1.
REQ-039 SHALL cover rst asserted mid-WAIT -> next cycle busy=0, isect_start=0, done=0, hit_t=0x7FFFFFFF; ray_start during busy -> no restart.

Source files
------------

// File: rtl/ray_pkg.sv
// Shared types and constants for the ray/sphere scan datapath.
package ray_pkg;

    localparam int unsigned WORD_W = 32;

    // 16.16 fixed-point one, and the "no hit yet" distance.
    localparam logic [WORD_W-1:0] FP_ONE = 32'h0001_0000;
    localparam logic [WORD_W-1:0] T_INF  = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_UPDATE,
        ST_DONE
    } scan_state_e;

    // Ray payload, latched once per scan.
    typedef struct packed {
        logic [WORD_W-1:0] orig_x;
        logic [WORD_W-1:0] orig_y;
        logic [WORD_W-1:0] orig_z;
        logic [WORD_W-1:0] dir_x;
        logic [WORD_W-1:0] dir_y;
        logic [WORD_W-1:0] dir_z;
    } ray_t;

    // Sphere table entry, loaded once per sphere.
    typedef struct packed {
        logic [WORD_W-1:0] center_x;
        logic [WORD_W-1:0] center_y;
        logic [WORD_W-1:0] center_z;
        logic [WORD_W-1:0] radius_sqr;
    } sphere_t;

endpackage

// File: rtl/nearest_hit_sel.sv
// Picks the candidate distance for one sphere and decides whether it beats
// the best distance so far. Purely combinational.
import ray_pkg::*;

module nearest_hit_sel (
    input  logic              result_i,
    input  logic              timed_out_i,
    input  logic [WORD_W-1:0] t0_i,
    input  logic [WORD_W-1:0] t1_i,
    input  logic [WORD_W-1:0] best_t_i,
    output logic [WORD_W-1:0] cand_t_c_o,
    output logic              accept_c_o
);

    // Near root if it lies in front of the origin, otherwise the far root;
    // strict less-than keeps the lower index on equal distances.
    always_comb begin
        cand_t_c_o = ($signed(t0_i) > $signed(32'sd0)) ? t0_i : t1_i;
        accept_c_o = result_i && !timed_out_i
                  && ($signed(cand_t_c_o) > $signed(32'sd0))
                  && ($signed(cand_t_c_o) < $signed(best_t_i));
    end

endmodule

// File: rtl/sphere_scan.sv
// Walks a sphere table for one ray, drives an external intersection unit per
// sphere and keeps the nearest positive hit.
import ray_pkg::*;

module sphere_scan #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ray_start,
    input  logic [ADDR_W:0]   num_spheres,
    input  logic [WORD_W-1:0] rayorig_x,
    input  logic [WORD_W-1:0] rayorig_y,
    input  logic [WORD_W-1:0] rayorig_z,
    input  logic [WORD_W-1:0] raydir_x,
    input  logic [WORD_W-1:0] raydir_y,
    input  logic [WORD_W-1:0] raydir_z,

    output logic              sph_rd,
    output logic [ADDR_W-1:0] sph_addr,
    input  logic [WORD_W-1:0] sph_center_x,
    input  logic [WORD_W-1:0] sph_center_y,
    input  logic [WORD_W-1:0] sph_center_z,
    input  logic [WORD_W-1:0] sph_radius_sqr,

    output logic              isect_start,
    output logic [WORD_W-1:0] isect_rayorig_x,
    output logic [WORD_W-1:0] isect_rayorig_y,
    output logic [WORD_W-1:0] isect_rayorig_z,
    output logic [WORD_W-1:0] isect_raydir_x,
    output logic [WORD_W-1:0] isect_raydir_y,
    output logic [WORD_W-1:0] isect_raydir_z,
    output logic [WORD_W-1:0] isect_center_x,
    output logic [WORD_W-1:0] isect_center_y,
    output logic [WORD_W-1:0] isect_center_z,
    output logic [WORD_W-1:0] isect_radius_sqr,
    input  logic              isect_finish,
    input  logic              isect_result,
    input  logic [WORD_W-1:0] isect_t0,
    input  logic [WORD_W-1:0] isect_t1,

    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [ADDR_W-1:0] hit_idx,
    output logic [WORD_W-1:0] hit_t
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    scan_state_e       state_q, state_d;
    ray_t              ray_q, ray_d;
    sphere_t           sph_q, sph_d;
    logic [IDX_W-1:0]  num_q, num_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] best_t_q, best_t_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              to_q, to_d;
    logic              sph_rd_q, sph_rd_d;
    logic [ADDR_W-1:0] sph_addr_q, sph_addr_d;
    logic              isect_start_q, isect_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] hit_idx_q, hit_idx_d;
    logic [WORD_W-1:0] hit_t_q, hit_t_d;

    logic [WORD_W-1:0] cand_t_c;
    logic              accept_c;
    logic              fin_ok_c;
    logic              wait_expired_c;
    logic [IDX_W-1:0]  idx_next_c;
    logic              more_c;

    // The first WAIT cycle may still see the previous operation's finish level.
    assign fin_ok_c       = (cnt_q != '0) && isect_finish;
    assign wait_expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign idx_next_c     = idx_q + IDX_W'(1);
    assign more_c         = (idx_next_c < num_q);

    nearest_hit_sel u_sel (
        .result_i    (isect_result),
        .timed_out_i (to_q),
        .t0_i        (isect_t0),
        .t1_i        (isect_t1),
        .best_t_i    (best_t_q),
        .cand_t_c_o  (cand_t_c),
        .accept_c_o  (accept_c)
    );

    // State register; reset wins over everything, including a pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ray_start) begin
                    state_d = (num_spheres == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH:  state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_START;
            ST_START:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (fin_ok_c || wait_expired_c) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: state_d = more_c ? ST_FETCH : ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; strobes look ahead to the next state
    // so that their registered copies line up with FETCH and START.
    always_comb begin
        ray_d         = ray_q;
        sph_d         = sph_q;
        num_d         = num_q;
        idx_d         = idx_q;
        best_t_d      = best_t_q;
        cnt_d         = cnt_q;
        to_d          = to_q;
        hit_d         = hit_q;
        hit_idx_d     = hit_idx_q;
        hit_t_d       = hit_t_q;
        sph_addr_d    = sph_addr_q;
        done_d        = 1'b0;
        busy_d        = (state_d != ST_IDLE);
        sph_rd_d      = (state_d == ST_FETCH);
        isect_start_d = (state_d == ST_START);

        case (state_q)
            ST_IDLE: begin
                if (ray_start) begin
                    ray_d.orig_x = rayorig_x;
                    ray_d.orig_y = rayorig_y;
                    ray_d.orig_z = rayorig_z;
                    ray_d.dir_x  = raydir_x;
                    ray_d.dir_y  = raydir_y;
                    ray_d.dir_z  = raydir_z;
                    num_d        = num_spheres;
                    idx_d        = '0;
                    best_t_d     = T_INF;
                    hit_d        = 1'b0;
                end
            end
            ST_LOAD: begin
                sph_d.center_x   = sph_center_x;
                sph_d.center_y   = sph_center_y;
                sph_d.center_z   = sph_center_z;
                sph_d.radius_sqr = sph_radius_sqr;
            end
            ST_START: begin
                cnt_d = '0;
                to_d  = 1'b0;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                to_d  = !fin_ok_c;
            end
            ST_UPDATE: begin
                if (accept_c) begin
                    best_t_d  = cand_t_c;
                    hit_idx_d = idx_q[ADDR_W-1:0];
                    hit_d     = 1'b1;
                end
                if (more_c) begin
                    idx_d = idx_next_c;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                hit_t_d = best_t_q;
            end
            default: ;
        endcase

        if (state_d == ST_FETCH) begin
            sph_addr_d = idx_d[ADDR_W-1:0];
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ray_q         <= '0;
            sph_q         <= '0;
            num_q         <= '0;
            idx_q         <= '0;
            best_t_q      <= T_INF;
            cnt_q         <= '0;
            to_q          <= 1'b0;
            sph_rd_q      <= 1'b0;
            sph_addr_q    <= '0;
            isect_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            hit_q         <= 1'b0;
            hit_idx_q     <= '0;
            hit_t_q       <= T_INF;
        end else begin
            ray_q         <= ray_d;
            sph_q         <= sph_d;
            num_q         <= num_d;
            idx_q         <= idx_d;
            best_t_q      <= best_t_d;
            cnt_q         <= cnt_d;
            to_q          <= to_d;
            sph_rd_q      <= sph_rd_d;
            sph_addr_q    <= sph_addr_d;
            isect_start_q <= isect_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
            hit_t_q       <= hit_t_d;
        end
    end

    assign sph_rd           = sph_rd_q;
    assign sph_addr         = sph_addr_q;
    assign isect_start      = isect_start_q;
    assign isect_rayorig_x  = ray_q.orig_x;
    assign isect_rayorig_y  = ray_q.orig_y;
    assign isect_rayorig_z  = ray_q.orig_z;
    assign isect_raydir_x   = ray_q.dir_x;
    assign isect_raydir_y   = ray_q.dir_y;
    assign isect_raydir_z   = ray_q.dir_z;
    assign isect_center_x   = sph_q.center_x;
    assign isect_center_y   = sph_q.center_y;
    assign isect_center_z   = sph_q.center_z;
    assign isect_radius_sqr = sph_q.radius_sqr;
    assign busy             = busy_q;
    assign done             = done_q;
    assign hit              = hit_q;
    assign hit_idx          = hit_idx_q;
    assign hit_t            = hit_t_q;

endmodule

// File: tb/tb_sphere_scan.sv
// Directed bench for sphere_scan with a behavioural intersection stub whose
// finish latency, stale-finish behaviour and per-sphere results are set per test.
import ray_pkg::*;

module tb_sphere_scan;

    localparam int unsigned AW     = 4;
    localparam int unsigned TO     = 15;
    localparam int          BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ray_start = 1'b0;
    logic [AW:0] num_spheres = '0;
    logic [31:0] rayorig_x = '0, rayorig_y = '0, rayorig_z = '0;
    logic [31:0] raydir_x = '0, raydir_y = '0, raydir_z = '0;
    logic        sph_rd;
    logic [AW-1:0] sph_addr;
    logic [31:0] sph_center_x = '0, sph_center_y = '0, sph_center_z = '0, sph_radius_sqr = '0;
    logic        isect_start;
    logic [31:0] isect_rayorig_x, isect_rayorig_y, isect_rayorig_z;
    logic [31:0] isect_raydir_x, isect_raydir_y, isect_raydir_z;
    logic [31:0] isect_center_x, isect_center_y, isect_center_z, isect_radius_sqr;
    logic        isect_finish = 1'b0;
    logic        isect_result = 1'b0;
    logic [31:0] isect_t0 = '0, isect_t1 = '0;
    logic        busy, done, hit;
    logic [AW-1:0] hit_idx;
    logic [31:0] hit_t;

    int n_cmp = 0;
    int n_err = 0;

    // Stub configuration and state.
    logic        tab_res  [16];
    logic [31:0] tab_t0   [16];
    logic [31:0] tab_t1   [16];
    logic        tab_hang [16];
    int          lat = 1;
    logic        stale_mode = 1'b0;
    logic        pend = 1'b0;
    int          rem = 0;
    logic [AW-1:0] cur = '0;

    sphere_scan #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ray_start(ray_start), .num_spheres(num_spheres),
        .rayorig_x(rayorig_x), .rayorig_y(rayorig_y), .rayorig_z(rayorig_z),
        .raydir_x(raydir_x), .raydir_y(raydir_y), .raydir_z(raydir_z),
        .sph_rd(sph_rd), .sph_addr(sph_addr),
        .sph_center_x(sph_center_x), .sph_center_y(sph_center_y),
        .sph_center_z(sph_center_z), .sph_radius_sqr(sph_radius_sqr),
        .isect_start(isect_start),
        .isect_rayorig_x(isect_rayorig_x), .isect_rayorig_y(isect_rayorig_y),
        .isect_rayorig_z(isect_rayorig_z),
        .isect_raydir_x(isect_raydir_x), .isect_raydir_y(isect_raydir_y),
        .isect_raydir_z(isect_raydir_z),
        .isect_center_x(isect_center_x), .isect_center_y(isect_center_y),
        .isect_center_z(isect_center_z), .isect_radius_sqr(isect_radius_sqr),
        .isect_finish(isect_finish), .isect_result(isect_result),
        .isect_t0(isect_t0), .isect_t1(isect_t1),
        .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx), .hit_t(hit_t)
    );

    always #5 clk = ~clk;

    // Sphere table: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (sph_rd) begin
            sph_center_x   <= FP_ONE * 32'(sph_addr + 1);
            sph_center_y   <= 32'h0000_8000;
            sph_center_z   <= 32'hFFFF_0000;
            sph_radius_sqr <= 32'h0000_4000;
        end
    end

    // Intersection stub: finish is a level that rises 'lat' edges after start.
    always @(posedge clk) begin
        if (isect_start) begin
            cur <= sph_addr;
            if (tab_hang[sph_addr]) begin
                pend         <= 1'b0;
                isect_finish <= 1'b0;
                isect_result <= 1'b1;
                isect_t0     <= 32'h0000_8000;
                isect_t1     <= 32'h0000_8000;
            end else begin
                pend <= 1'b1;
                rem  <= lat;
                if (!stale_mode) isect_finish <= 1'b0;
            end
        end else if (pend) begin
            if (rem <= 1) begin
                pend         <= 1'b0;
                isect_finish <= 1'b1;
                isect_result <= tab_res[cur];
                isect_t0     <= tab_t0[cur];
                isect_t1     <= tab_t1[cur];
            end else begin
                rem <= rem - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_sph(input int i, input logic r, input logic [31:0] a,
                           input logic [31:0] b, input logic h);
        tab_res[i]  = r;
        tab_t0[i]   = a;
        tab_t1[i]   = b;
        tab_hang[i] = h;
    endtask

    // Launch a scan, optionally poke ray_start again while busy, and check
    // done latency plus the single-cycle done pulse.
    task automatic run_scan(input string tag, input int n, input int exp_lat, input int poke);
        int seen;
        seen = -1;
        @(negedge clk);
        ray_start   = 1'b1;
        num_spheres = (AW+1)'(n);
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (k == 1) ray_start = 1'b0;
            if (poke != 0 && k == poke) begin
                ray_start   = 1'b1;
                num_spheres = '0;
                rayorig_x   = 32'hDEAD_0000;
            end
            if (poke != 0 && k == poke + 1) ray_start = 1'b0;
            if (done === 1'b1) begin
                seen = k;
                break;
            end
        end
        chk({tag, " latency"}, 32'(seen), 32'(exp_lat));
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) set_sph(i, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst hit", 32'(hit), 32'd0);
        chk("rst hit_idx", 32'(hit_idx), 32'd0);
        chk("rst hit_t", hit_t, T_INF);
        chk("rst sph_rd", 32'(sph_rd), 32'd0);
        chk("rst isect_start", 32'(isect_start), 32'd0);
        chk("rst center_x", isect_center_x, 32'h0);

        // Empty scan.
        run_scan("empty", 0, 2, 0);
        chk("empty hit", 32'(hit), 32'd0);
        chk("empty hit_t", hit_t, T_INF);

        // Two spheres, only the first hits.
        lat = 1;
        set_sph(0, 1'b1, 32'h0004_0000, 32'h0006_0000, 1'b0);
        set_sph(1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        run_scan("two", 2, 14, 0);
        chk("two hit", 32'(hit), 32'd1);
        chk("two hit_idx", 32'(hit_idx), 32'd0);
        chk("two hit_t", hit_t, 32'h0004_0000);

        // Three hits, tie on distance keeps the lower index; slower stub.
        lat = 3;
        set_sph(0, 1'b1, 32'h0006_0000, 32'h0007_0000, 1'b0);
        set_sph(1, 1'b1, 32'h0003_0000, 32'h0007_0000, 1'b0);
        set_sph(2, 1'b1, 32'h0003_0000, 32'h0007_0000, 1'b0);
        run_scan("three", 3, 26, 0);
        chk("three hit", 32'(hit), 32'd1);
        chk("three hit_idx", 32'(hit_idx), 32'd1);
        chk("three hit_t", hit_t, 32'h0003_0000);

        // Origin inside; stale finish=1 (t0=3.0) visible in the first WAIT cycle.
        lat = 1;
        stale_mode = 1'b1;
        set_sph(0, 1'b1, 32'hFFFF_0000, 32'h0002_0000, 1'b0);
        run_scan("inside", 1, 8, 0);
        chk("inside hit", 32'(hit), 32'd1);
        chk("inside hit_idx", 32'(hit_idx), 32'd0);
        chk("inside hit_t", hit_t, 32'h0002_0000);
        stale_mode = 1'b0;

        // First sphere never finishes and must be dropped after the timeout.
        set_sph(0, 1'b1, 32'h0000_8000, 32'h0000_8000, 1'b1);
        set_sph(1, 1'b1, 32'h0001_0000, 32'h0002_0000, 1'b0);
        run_scan("timeout", 2, 2 + (4 + TO) + 6, 0);
        chk("timeout hit", 32'(hit), 32'd1);
        chk("timeout hit_idx", 32'(hit_idx), 32'd1);
        chk("timeout hit_t", hit_t, 32'h0001_0000);

        // Reset while waiting on a hung sphere.
        set_sph(0, 1'b1, 32'h0, 32'h0, 1'b1);
        rayorig_x = 32'h0001_0000; rayorig_y = 32'h0002_0000; rayorig_z = 32'h0003_0000;
        raydir_x  = 32'h0000_0000; raydir_y  = 32'h0000_0000; raydir_z  = 32'hFFFF_0000;
        @(negedge clk);
        ray_start   = 1'b1;
        num_spheres = (AW+1)'(1);
        @(negedge clk);
        ray_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait busy", 32'(busy), 32'd1);
        chk("wait center_x", isect_center_x, 32'h0001_0000);
        chk("wait radius", isect_radius_sqr, 32'h0000_4000);
        chk("wait orig_z", isect_rayorig_z, 32'h0003_0000);
        chk("wait dir_z", isect_raydir_z, 32'hFFFF_0000);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst isect_start", 32'(isect_start), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst hit_t", hit_t, T_INF);
        chk("midrst hit_idx", 32'(hit_idx), 32'd0);
        chk("midrst orig_x", isect_rayorig_x, 32'h0);
        rst = 1'b0;

        // Second ray_start while busy must be ignored.
        set_sph(0, 1'b1, 32'h0005_0000, 32'h0006_0000, 1'b0);
        run_scan("busy", 1, 8, 3);
        chk("busy hit", 32'(hit), 32'd1);
        chk("busy hit_t", hit_t, 32'h0005_0000);
        chk("busy orig_x", isect_rayorig_x, 32'h0001_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
